// File: rtl/stream_shift_pkg.sv
`default_nettype none
// ============================================================================
// Package     : stream_shift_pkg
// Description : Shared state encoding and width helper for stream_shift_reg.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_shift_pkg;

    // Controller states: collecting chunks, holding a full word, unloading a word.
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FULL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Width of a counter that must represent every value 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : stream_shift_pkg
`default_nettype wire

// File: rtl/stream_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : stream_shift_reg
// Description : Bidirectional chunk shifter. Serially collects INPUT_WIDTH
//               chunks into a DATA_WIDTH word (newest in the LSBs), or loads a
//               parallel word and unloads it MSB chunk first.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_shift_reg
    import stream_shift_pkg::*;
#(
    parameter  int INPUT_WIDTH = 8,
    parameter  int DATA_WIDTH  = 640,
    localparam int N           = DATA_WIDTH / INPUT_WIDTH,
    localparam int CNT_W       = cnt_w(N)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INPUT_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0]  q,
    output logic                   q_valid,
    input  logic                   q_ack,
    input  logic                   par_load,
    output logic                   par_ready,
    input  logic [DATA_WIDTH-1:0]  par_d,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INPUT_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]       count
);

    // Reject geometries that cannot be split into at least two whole chunks.
    generate
        if ((DATA_WIDTH % INPUT_WIDTH) != 0 || N < 2) begin : g_bad_geometry
            $error("stream_shift_reg: DATA_WIDTH must be a multiple of INPUT_WIDTH with N >= 2");
        end
    endgenerate

    localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(N);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    state_t                  r_state, w_state_next;
    logic [DATA_WIDTH-1:0]   r_q,     w_q_next;
    logic [CNT_W-1:0]        r_count, w_count_next;

    // Status outputs decode only from registered state; in_ready also sees
    // par_load and clear so a colliding chunk is never half-accepted.
    assign in_ready  = (r_state == FILL) && !par_load && !clear;
    assign q_valid   = (r_state == FULL);
    assign out_valid = (r_state == DRAIN);
    assign par_ready = (r_state != DRAIN);
    assign q         = r_q;
    assign count     = r_count;
    assign out_data  = r_q[DATA_WIDTH-1 -: INPUT_WIDTH];

    // State, word and occupancy registers; reset aborts any fill or drain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= FILL;
            r_q     <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_q     <= w_q_next;
            r_count <= w_count_next;
        end
    end

    // Next-state and datapath: clear, then parallel load, then shifting.
    always_comb begin
        w_state_next = r_state;
        w_q_next     = r_q;
        w_count_next = r_count;

        if (clear) begin
            w_state_next = FILL;
            w_q_next     = '0;
            w_count_next = '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (par_load) begin
                        w_state_next = DRAIN;
                        w_q_next     = par_d;
                        w_count_next = C_CNT_FULL;
                    end else if (in_valid) begin
                        w_q_next = {r_q[DATA_WIDTH-INPUT_WIDTH-1:0], in_data};
                        if (r_count == C_CNT_LAST) begin
                            w_state_next = FULL;
                            w_count_next = C_CNT_FULL;
                        end else begin
                            w_count_next = r_count + C_CNT_ONE;
                        end
                    end
                end
                FULL: begin
                    if (par_load) begin
                        w_state_next = DRAIN;
                        w_q_next     = par_d;
                        w_count_next = C_CNT_FULL;
                    end else if (q_ack) begin
                        // Word stays visible on q; only the occupancy restarts.
                        w_state_next = FILL;
                        w_count_next = '0;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (r_count == C_CNT_ONE) begin
                            w_state_next = FILL;
                            w_q_next     = '0;
                            w_count_next = '0;
                        end else begin
                            w_q_next     = {r_q[DATA_WIDTH-INPUT_WIDTH-1:0], {INPUT_WIDTH{1'b0}}};
                            w_count_next = r_count - C_CNT_ONE;
                        end
                    end
                end
                default: begin
                    w_state_next = FILL;
                    w_q_next     = '0;
                    w_count_next = '0;
                end
            endcase
        end
    end

endmodule : stream_shift_reg
`default_nettype wire

// File: tb/tb_stream_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_shift_reg
// Description : Directed and randomized self-checking bench for
//               stream_shift_reg with 8-bit chunks and 32-bit words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_shift_reg;

    localparam int IW = 8;
    localparam int DW = 32;
    localparam int NC = DW / IW;
    localparam int CW = $clog2(NC + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic [DW-1:0] q;
    logic          q_valid;
    logic          q_ack;
    logic          par_load;
    logic          par_ready;
    logic [DW-1:0] par_d;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_data;
    logic [CW-1:0] count;

    int num_checks = 0;
    int num_errors = 0;

    stream_shift_reg #(.INPUT_WIDTH(IW), .DATA_WIDTH(DW)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .q         (q),
        .q_valid   (q_valid),
        .q_ack     (q_ack),
        .par_load  (par_load),
        .par_ready (par_ready),
        .par_d     (par_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    // 100 MHz clock.
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        q_ack     = 1'b0;
        par_load  = 1'b0;
        par_d     = '0;
        out_ready = 1'b0;
    endtask

    task automatic push_chunk(input logic [IW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Reference model state for the random phase.
    logic [IW-1:0] mq[$];
    int            mmode;   // 0 = FILL, 1 = FULL, 2 = DRAIN
    logic [DW-1:0] packed_q;
    logic [DW-1:0] tmp_word;

    initial begin
        logic [IW-1:0] drain_exp [5];
        logic          drain_rdy [5];
        drain_exp = '{8'hA1, 8'hB2, 8'hB2, 8'hC3, 8'hD4};
        drain_rdy = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        idle_inputs();
        reset = 1'b0;
        #23;
        // Reset values
        check_value("rst_q",         q,         0);
        check_value("rst_count",     count,     0);
        check_value("rst_q_valid",   q_valid,   0);
        check_value("rst_out_valid", out_valid, 0);
        check_value("rst_par_ready", par_ready, 1);
        check_value("rst_in_ready",  in_ready,  1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();

        // Serial fill
        push_chunk(8'h11);
        push_chunk(8'h22);
        push_chunk(8'h33);
        check_value("fill3_count",   count,   3);
        check_value("fill3_q_valid", q_valid, 0);
        push_chunk(8'h44);
        check_value("fill_q",        q,        32'h11223344);
        check_value("fill_q_valid",  q_valid,  1);
        check_value("fill_count",    count,    4);
        check_value("fill_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_data  = 8'h99;
        tick();
        in_valid = 1'b0;
        check_value("full_hold_q",        q,        32'h11223344);
        check_value("full_hold_in_ready", in_ready, 0);
        q_ack = 1'b1;
        tick();
        q_ack = 1'b0;
        check_value("ack_q_valid",  q_valid,  0);
        check_value("ack_count",    count,    0);
        check_value("ack_q",        q,        32'h11223344);
        check_value("ack_in_ready", in_ready, 1);

        // Parallel load and drain with backpressure
        par_load = 1'b1;
        par_d    = 32'hA1B2C3D4;
        #1;
        check_value("load_par_ready", par_ready, 1);
        tick();
        par_load = 1'b0;
        check_value("load_out_valid", out_valid, 1);
        check_value("load_count",     count,     4);
        check_value("load_par_ready2", par_ready, 0);
        for (int i = 0; i < 5; i++) begin
            out_ready = drain_rdy[i];
            #1;
            check_value($sformatf("drain_data%0d", i), out_data, drain_exp[i]);
            tick();
        end
        out_ready = 1'b0;
        check_value("drain_end_out_valid", out_valid, 0);
        check_value("drain_end_q",         q,         0);
        check_value("drain_end_count",     count,     0);
        check_value("drain_end_in_ready",  in_ready,  1);

        // Collision: par_load wins over a same-cycle chunk
        push_chunk(8'h55);
        push_chunk(8'h66);
        check_value("coll_pre_count", count, 2);
        par_load = 1'b1;
        par_d    = 32'h01020304;
        in_valid = 1'b1;
        in_data  = 8'h77;
        #1;
        check_value("coll_in_ready", in_ready, 0);
        tick();
        check_value("coll_out_valid", out_valid, 1);
        check_value("coll_count",     count,     4);
        check_value("coll_q",         q,         32'h01020304);
        par_d = 32'hDEADBEEF;
        tick();
        par_load = 1'b0;
        in_valid = 1'b0;
        check_value("drain_ignore_q", q, 32'h01020304);

        // Clear in the middle of a drain
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check_value("mid_count",    count,    2);
        check_value("mid_out_data", out_data, 8'h03);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        check_value("clr_q",         q,         0);
        check_value("clr_count",     count,     0);
        check_value("clr_out_valid", out_valid, 0);
        check_value("clr_in_ready",  in_ready,  1);

        // Asynchronous reset while holding a full word
        push_chunk(8'hC0);
        push_chunk(8'hC1);
        push_chunk(8'hC2);
        push_chunk(8'hC3);
        check_value("pre_rst_q_valid", q_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check_value("arst_q_valid", q_valid, 0);
        check_value("arst_q",       q,       0);
        check_value("arst_count",   count,   0);
        tick();
        reset = 1'b1;
        tick();
        check_value("post_rst_q_valid", q_valid, 0);
        push_chunk(8'hE1);
        push_chunk(8'hE2);
        push_chunk(8'hE3);
        push_chunk(8'hE4);
        check_value("refill_q",       q,       32'hE1E2E3E4);
        check_value("refill_q_valid", q_valid, 1);
        q_ack = 1'b1;
        tick();
        q_ack = 1'b0;

        // Random valid/ready stress against a queue model
        mq.delete();
        mmode = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = IW'($urandom);
            q_ack     = $urandom_range(0, 3) == 0;
            par_load  = $urandom_range(0, 15) == 0;
            par_d     = DW'($urandom);
            out_ready = $urandom_range(0, 1) == 1;
            #1;
            check_value("rnd_count",     count,     mq.size());
            check_value("rnd_in_ready",  in_ready,  (mmode == 0) && !par_load);
            check_value("rnd_q_valid",   q_valid,   mmode == 1);
            check_value("rnd_out_valid", out_valid, mmode == 2);
            if (mmode == 2) begin
                check_value("rnd_out_data", out_data, mq[0]);
            end
            if (mmode == 1) begin
                packed_q = '0;
                foreach (mq[k]) packed_q = {packed_q[DW-IW-1:0], mq[k]};
                check_value("rnd_q", q, packed_q);
            end
            // Advance the model with the inputs the DUT sees at this edge.
            if (mmode != 2 && par_load) begin
                mq.delete();
                tmp_word = par_d;
                for (int k = 0; k < NC; k++) begin
                    mq.push_back(tmp_word[DW-1 -: IW]);
                    tmp_word = tmp_word << IW;
                end
                mmode = 2;
            end else if (mmode == 0) begin
                if (in_valid) mq.push_back(in_data);
                if (mq.size() == NC) mmode = 1;
            end else if (mmode == 1) begin
                if (q_ack) begin
                    mq.delete();
                    mmode = 0;
                end
            end else begin
                if (out_ready) void'(mq.pop_front());
                if (mq.size() == 0) mmode = 0;
            end
            tick();
        end
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule : tb_stream_shift_reg
`default_nettype wire

// File: doc/stream_shift_reg.md
STREAM_SHIFT_REG -- requirements
Module: stream_shift_reg

Interface
REQ-001 Parameter INPUT_WIDTH, default 8: chunk width in bits.
REQ-002 Parameter DATA_WIDTH, default 640: parallel word width in bits (80-byte block header).
REQ-003 Derived constant N = DATA_WIDTH/INPUT_WIDTH: chunks per word. CNT_W = clog2(N+1).
REQ-004 Port clock  in  1  rising-edge clock; one clock domain.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Port clear  in  1  synchronous flush; highest priority after reset.
REQ-007 Port in_valid  in  1  in_data holds a valid chunk.
REQ-008 Port in_ready  out  1  block accepts a chunk this cycle.
REQ-009 Port in_data  in  INPUT_WIDTH  serial input chunk.
REQ-010 Port q  out  DATA_WIDTH  parallel word; most recently received chunk in the LSBs.
REQ-011 Port q_valid  out  1  q holds N received chunks.
REQ-012 Port q_ack  in  1  consumer has taken q.
REQ-013 Port par_load  in  1  request to load par_d for serial unload.
REQ-014 Port par_ready  out  1  par_load is accepted this cycle.
REQ-015 Port par_d  in  DATA_WIDTH  parallel word to unload.
REQ-016 Port out_valid  out  1  out_data holds a valid chunk.
REQ-017 Port out_ready  in  1  downstream accepts out_data.
REQ-018 Port out_data  out  INPUT_WIDTH  q[DATA_WIDTH-1 -: INPUT_WIDTH], MSB chunk first.
REQ-019 Port count  out  CNT_W  number of chunks currently held, 0..N.

Function
REQ-020 FSM states: FILL, FULL and DRAIN. Outputs decode from registered state and count only, except in_ready.
REQ-021 FILL: in_ready = !par_load && !clear. A handshake (in_valid && in_ready) sets q <= {q[DATA_WIDTH-INPUT_WIDTH-1:0], in_data} and increments count.
REQ-022 FILL, handshake at count == N-1: go to FULL with count = N. q_valid is high from the next cycle.
REQ-023 FULL: in_ready = 0, q_valid = 1, q is held stable. q_ack returns to FILL with count = 0 and q unchanged.
REQ-024 par_ready = 1 in FILL and FULL, 0 in DRAIN.
REQ-025 par_load in FILL or FULL loads q <= par_d, sets count = N and goes to DRAIN. Any partial fill or pending q_valid word is discarded.
REQ-026 par_load has priority over a same-cycle in_valid and over q_ack.
REQ-027 DRAIN: out_valid = 1. On out_ready, q <= {q[DATA_WIDTH-INPUT_WIDTH-1:0], INPUT_WIDTH'b0} and count decrements.
REQ-028 DRAIN, out_ready at count == 1: go to FILL with count = 0 and q = 0.
REQ-029 out_valid = 0 outside DRAIN. par_load and in_valid are ignored in DRAIN.
REQ-030 clear in any state: q = 0, count = 0, next state FILL. The same-cycle handshake is not performed (in_ready = 0).
REQ-031 Shift distance is always INPUT_WIDTH, never a hard-coded 8.
REQ-032 DATA_WIDTH % INPUT_WIDTH == 0 and N >= 2. Elaboration fails otherwise.
REQ-033 Throughput: one chunk per cycle in both directions. Latency from the last fill handshake to q_valid is 1 cycle.

Reset
REQ-034 While reset is low: state = FILL, q = 0, count = 0, q_valid = 0, out_valid = 0, par_ready = 1.
REQ-035 Reset asserted mid-fill or mid-drain aborts the operation immediately; no partial output follows deassertion.

Structure
REQ-036 Package stream_shift_pkg holds the state enum (FILL, FULL, DRAIN) and the clog2-based CNT_W helper.
REQ-037 Single module; no sub-module. Datapath (q shifter, counter) and FSM live in one file.

Verification (bench parameters INPUT_WIDTH = 8, DATA_WIDTH = 32)
REQ-038 Fill: chunks 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> q = 0x11223344, q_valid = 1 and count = 4 one cycle after the 4th handshake; in_ready = 0 until q_ack.
REQ-039 Drain with backpressure: par_load with par_d = 0xA1B2C3D4, out_ready toggling 1,0,1,1,1 -> out_data sequence A1, B2, C3, D4. Each chunk is held while out_ready = 0. FILL with q = 0 after the last chunk.
REQ-040 Collision: in FILL at count = 2, par_load and in_valid together -> par_d loaded, input chunk not accepted (in_ready = 0), state DRAIN, count = 4.
REQ-041 clear mid-drain after 2 chunks -> next cycle q = 0, count = 0, out_valid = 0, in_ready = 1.
REQ-042 reset pulsed low during FULL -> immediate q_valid = 0, q = 0, count = 0. After release, a fresh 4-chunk fill completes normally.
REQ-043 Random valid/ready stress, 10k cycles, against a reference queue model -> no lost or duplicated chunks; count always equals the model occupancy.
